// File: rtl/hello_pkg.sv
// Shared definitions for the seven-segment scrolling message path:
// character code width, character codes and the scroll FSM state type.
package hello_pkg;

    localparam int unsigned CODE_W = 3;

    localparam logic [CODE_W-1:0] CHAR_H     = 3'd0;
    localparam logic [CODE_W-1:0] CHAR_E     = 3'd1;
    localparam logic [CODE_W-1:0] CHAR_L     = 3'd2;
    localparam logic [CODE_W-1:0] CHAR_O     = 3'd3;
    localparam logic [CODE_W-1:0] CHAR_BLANK = 3'd7;

    typedef enum logic [1:0] {
        PAUSE,
        RUN,
        HOLD
    } scroll_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running modulo-DIV counter; tc strobes for one cycle on the
// terminal count while enabled. clr holds the count at zero.
module tick_prescaler #(
    parameter int unsigned DIV = 12_500_000
) (
    input  logic CLOCK_50,
    input  logic KEY,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == CNT_LAST) ? '0 : count + 1'b1;
        end
    end

    assign tc = en && !clr && (count == CNT_LAST);

endmodule

// File: rtl/hex_scroll_engine.sv
// Scrolling-message engine: shifts message character codes through a
// NUM_DIGITS-deep digit chain under auto-scroll, hold and single-step control.
module hex_scroll_engine
    import hello_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned MSG_LEN    = 5,
    parameter int unsigned DIV        = 12_500_000,
    parameter int unsigned HOLD_TICKS = 4
) (
    input  logic                         CLOCK_50,
    input  logic                         KEY,
    input  logic                         run,
    input  logic                         dir,
    input  logic                         step,
    input  logic [MSG_LEN*CODE_W-1:0]    msg,
    output logic [NUM_DIGITS*CODE_W-1:0] q,
    output logic                         tick,
    output logic                         wrap
);

    localparam int unsigned PTR_W  = $clog2(MSG_LEN);
    localparam int unsigned HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(MSG_LEN - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_TICKS);

    scroll_state_t state, next_state;

    logic [CODE_W-1:0] digits [NUM_DIGITS];
    logic [CODE_W-1:0] chars  [MSG_LEN];
    logic [PTR_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic              step_d;
    logic              advanced;
    logic              step_rise;
    logic              tc;
    logic              advance;
    logic              wrap_now;
    logic              presc_clr;
    logic              hold_load;
    logic              hold_dec;
    logic              hold_clr;

    for (genvar gk = 0; gk < MSG_LEN; gk++) begin : g_chars
        assign chars[gk] = msg[gk*CODE_W +: CODE_W];
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_q
        assign q[gi*CODE_W +: CODE_W] = digits[gi];
    end

    // Prescaler sits cleared while paused, so RUN always starts a full period.
    tick_prescaler #(
        .DIV(DIV)
    ) u_prescaler (
        .CLOCK_50(CLOCK_50),
        .KEY     (KEY),
        .clr     (presc_clr),
        .en      (state != PAUSE),
        .tc      (tc)
    );

    assign step_rise = step && !step_d;
    // Right scroll starts at ptr 0, so the very first advance must not count as a wrap.
    assign wrap_now  = dir ? ((ptr == '0) && advanced) : (ptr == PTR_LAST);

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            state <= PAUSE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        advance    = 1'b0;
        presc_clr  = 1'b0;
        hold_load  = 1'b0;
        hold_dec   = 1'b0;
        hold_clr   = 1'b0;
        case (state)
            PAUSE: begin
                presc_clr = 1'b1;
                if (run) begin
                    next_state = RUN;
                end else if (step_rise) begin
                    advance = 1'b1;
                end
            end
            RUN: begin
                if (!run) begin
                    next_state = PAUSE;
                end else if (tc) begin
                    advance = 1'b1;
                    if (wrap_now && (HOLD_TICKS > 0)) begin
                        next_state = HOLD;
                        hold_load  = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (!run) begin
                    next_state = PAUSE;
                    hold_clr   = 1'b1;
                end else if (tc) begin
                    hold_dec = 1'b1;
                    if (hold_cnt <= HOLD_W'(1)) begin
                        next_state = RUN;
                    end
                end
            end
            default: next_state = PAUSE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                digits[i] <= CHAR_BLANK;
            end
            ptr      <= '0;
            hold_cnt <= '0;
            step_d   <= 1'b0;
            advanced <= 1'b0;
            tick     <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            step_d <= step;
            tick   <= advance;
            wrap   <= advance && wrap_now;
            if (advance) begin
                advanced <= 1'b1;
                if (!dir) begin
                    digits[0] <= chars[ptr];
                    for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
                        digits[i] <= digits[i-1];
                    end
                    ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
                end else begin
                    digits[NUM_DIGITS-1] <= chars[ptr];
                    for (int unsigned i = 0; i + 1 < NUM_DIGITS; i++) begin
                        digits[i] <= digits[i+1];
                    end
                    ptr <= (ptr == '0) ? PTR_LAST : ptr - 1'b1;
                end
            end
            if (hold_load) begin
                hold_cnt <= HOLD_INIT;
            end else if (hold_clr) begin
                hold_cnt <= '0;
            end else if (hold_dec) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hex_scroll_engine.sv
// Directed bench for hex_scroll_engine with a scoreboard of expected
// advances (cycle, digits, wrap) popped whenever the engine ticks.
module tb_hex_scroll_engine;
    import hello_pkg::*;

    typedef struct {
        int         cyc;
        logic [11:0] q;
        logic       wrap;
    } exp_t;

    logic        clk = 1'b0;
    logic        KEY;
    logic        run;
    logic        dir;
    logic        step;
    logic [14:0] msg;
    logic [11:0] q;
    logic        tick;
    logic        wrap;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_t       sb [$];
    logic [2:0] mq   [4];
    logic [2:0] mmsg [5];
    int         mptr;
    bit         madv;

    hex_scroll_engine #(
        .NUM_DIGITS(4),
        .MSG_LEN   (5),
        .DIV       (4),
        .HOLD_TICKS(2)
    ) dut (
        .CLOCK_50(clk),
        .KEY     (KEY),
        .run     (run),
        .dir     (dir),
        .step    (step),
        .msg     (msg),
        .q       (q),
        .tick    (tick),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mq[i] = CHAR_BLANK;
        mptr = 0;
        madv = 1'b0;
    endtask

    // Predict one advance in direction d, expected to be visible after edge 'at'.
    task automatic model_adv(input bit d, input int at);
        exp_t e;
        bit   w;
        if (!d) begin
            w = (mptr == 4);
            for (int i = 3; i > 0; i--) mq[i] = mq[i-1];
            mq[0] = mmsg[mptr];
            mptr = (mptr == 4) ? 0 : mptr + 1;
        end else begin
            w = (mptr == 0) && madv;
            for (int i = 0; i < 3; i++) mq[i] = mq[i+1];
            mq[3] = mmsg[mptr];
            mptr = (mptr == 0) ? 4 : mptr - 1;
        end
        madv   = 1'b1;
        e.cyc  = at;
        e.q    = {mq[3], mq[2], mq[1], mq[0]};
        e.wrap = w;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic chk_drained(input string tag);
        chk(tag, 16'(sb.size()), 16'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (tick === 1'b1) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL tick_expected observed=tick@%0d expected=no_tick", cyc);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                assert (cyc === e.cyc) else begin
                    errors++;
                    $error("FAIL tick_cycle observed=%0d expected=%0d", cyc, e.cyc);
                end
                checks++;
                assert (q === e.q) else begin
                    errors++;
                    $error("FAIL tick_q observed=%h expected=%h", q, e.q);
                end
                checks++;
                assert (wrap === e.wrap) else begin
                    errors++;
                    $error("FAIL tick_wrap observed=%b expected=%b", wrap, e.wrap);
                end
            end
        end else begin
            checks++;
            assert (wrap === 1'b0) else begin
                errors++;
                $error("FAIL wrap_without_tick observed=%b expected=0", wrap);
            end
        end
    end

    initial begin
        int c;
        int s;
        int r;
        logic [2:0] q3_seq [6];

        mmsg   = '{CHAR_H, CHAR_E, CHAR_L, CHAR_L, CHAR_O};
        q3_seq = '{CHAR_H, CHAR_O, CHAR_L, CHAR_L, CHAR_E, CHAR_H};
        msg    = {CHAR_O, CHAR_L, CHAR_L, CHAR_E, CHAR_H};
        KEY    = 1'b1;
        run    = 1'b0;
        dir    = 1'b0;
        step   = 1'b0;
        model_reset();

        // Reset state
        #1 KEY = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_q", 16'(q), 16'h0FFF);
        chk("rst_tick", 16'(tick), 16'd0);
        chk("rst_wrap", 16'(wrap), 16'd0);
        chk("rst_state", 16'(dut.state), 16'(PAUSE));
        KEY = 1'b1;
        @(negedge clk);

        // Left auto-scroll, wrap, then hold
        c   = cyc;
        run = 1'b1;
        dir = 1'b0;
        for (int k = 0; k < 5; k++) model_adv(1'b0, c + 5 + 4 * k);
        wait_until(c + 21);
        chk("left5_q", 16'(q), 16'({CHAR_E, CHAR_L, CHAR_L, CHAR_O}));
        chk("left5_wrap", 16'(wrap), 16'd1);
        chk("left5_state", 16'(dut.state), 16'(HOLD));
        model_adv(1'b0, c + 33);
        wait_until(c + 32);
        chk("hold_q", 16'(q), 16'({CHAR_E, CHAR_L, CHAR_L, CHAR_O}));
        wait_until(c + 33);
        chk("hold_exit_q", 16'(q), 16'({CHAR_L, CHAR_L, CHAR_O, CHAR_H}));

        // Direction flip mid-run, then run dropped on the terminal count
        dir = 1'b1;
        model_adv(1'b1, c + 37);
        wait_until(c + 36);
        chk("flip_q_hold", 16'(q), 16'({CHAR_L, CHAR_L, CHAR_O, CHAR_H}));
        wait_until(c + 37);
        chk("flip_q_next", 16'(q), 16'({CHAR_E, CHAR_L, CHAR_L, CHAR_O}));
        wait_until(c + 40);
        run = 1'b0;
        wait_until(c + 41);
        chk("race_state", 16'(dut.state), 16'(PAUSE));
        chk("race_q", 16'(q), 16'({CHAR_E, CHAR_L, CHAR_L, CHAR_O}));
        chk("race_tick", 16'(tick), 16'd0);
        repeat (2) @(negedge clk);
        chk_drained("race_drained");

        // Held step gives one advance
        dir  = 1'b0;
        s    = cyc;
        model_adv(1'b0, s + 1);
        step = 1'b1;
        repeat (10) @(negedge clk);
        step = 1'b0;
        repeat (2) @(negedge clk);
        chk_drained("step_held");

        // Three separate step pulses
        for (int k = 0; k < 3; k++) begin
            model_adv(1'b0, cyc + 1);
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            @(negedge clk);
        end
        chk_drained("step_pulses");

        // Steps ignored while running
        r   = cyc;
        run = 1'b1;
        model_adv(1'b0, r + 5);
        @(negedge clk) step = 1'b1;
        @(negedge clk) step = 1'b0;
        @(negedge clk) step = 1'b1;
        @(negedge clk) step = 1'b0;
        wait_until(r + 6);
        run = 1'b0;
        repeat (3) @(negedge clk);
        chk_drained("step_in_run");
        chk("step_in_run_state", 16'(dut.state), 16'(PAUSE));

        // Asynchronous reset mid-run blanks q without a clock edge
        run = 1'b1;
        repeat (3) @(negedge clk);
        KEY = 1'b0;
        #1;
        chk("async_rst_q", 16'(q), 16'h0FFF);
        chk("async_rst_tick", 16'(tick), 16'd0);
        run = 1'b0;
        dir = 1'b1;
        model_reset();
        @(negedge clk) KEY = 1'b1;
        @(negedge clk);
        chk("post_rst_state", 16'(dut.state), 16'(PAUSE));

        // Right scroll by stepping from reset
        for (int k = 0; k < 6; k++) begin
            model_adv(1'b1, cyc + 1);
            step = 1'b1;
            @(negedge clk);
            chk($sformatf("right_q3_%0d", k), 16'(q[11:9]), 16'(q3_seq[k]));
            chk($sformatf("right_wrap_%0d", k), 16'(wrap), (k == 5) ? 16'd1 : 16'd0);
            step = 1'b0;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        chk_drained("final_drained");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
